// File: rtl/dht11_uart_reporter_if.sv
// Bundle between the reporter, the DHT11 controller and the UART TX FIFO write port.
// master: the reporter side. slave: the controller/FIFO side.
interface dht11_uart_reporter_if;
  logic       dht_start;
  logic       dht_done;
  logic       dht_valid;
  logic [7:0] rh_data;
  logic [7:0] t_data;
  logic       fifo_full;
  logic       fifo_push;
  logic [7:0] fifo_wdata;

  modport master (
    output dht_start, fifo_push, fifo_wdata,
    input  dht_done, dht_valid, rh_data, t_data, fifo_full
  );

  modport slave (
    input  dht_start, fifo_push, fifo_wdata,
    output dht_done, dht_valid, rh_data, t_data, fifo_full
  );
endinterface

// File: rtl/dht11_uart_reporter.sv
// DHT11 measurement reporter: triggers reads (periodic or on request), converts
// humidity/temperature to 3-digit decimal ASCII and writes one text line per
// read into the UART TX FIFO ("H=hhh T=ttt\r\n" or "ERR\r\n").
// Optional feature: define DHT_REPORT_SEQ_EN to prefix each line with "#XX "
// (8-bit uppercase-hex line sequence number).
module dht11_uart_reporter #(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned PERIOD_MS  = 2000,
  parameter int unsigned TIMEOUT_MS = 50
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          auto_en,
  input  logic                          req,
  dht11_uart_reporter_if.master         io,
  output logic                          busy,
  output logic [7:0]                    err_cnt
);

  localparam int unsigned PERIOD_CYC  = CLK_HZ / 1000 * PERIOD_MS;
  localparam int unsigned TIMEOUT_CYC = CLK_HZ / 1000 * TIMEOUT_MS;
  localparam int unsigned PER_W       = (PERIOD_CYC > 1) ? $clog2(PERIOD_CYC) : 1;
  localparam int unsigned TMO_W       = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
`ifdef DHT_REPORT_SEQ_EN
  localparam int unsigned PFX_LEN = 4;
`else
  localparam int unsigned PFX_LEN = 0;
`endif
  localparam int unsigned GOOD_LEN = 13 + PFX_LEN;
  localparam int unsigned ERR_LEN  = 5 + PFX_LEN;

  typedef enum logic [2:0] {IDLE, TRIG, WAIT_DONE, CONV, SEND, ERR_SEND} state_t;

  state_t           state, next_state;
  logic             pending;
  logic [PER_W-1:0] period_cnt;
  logic [TMO_W-1:0] tmo_cnt;
  logic             period_wrap, tmo_hit;

  // Conversion datapath: work holds the remainder of the value being converted.
  logic [7:0]  work;
  logic [1:0]  hun;
  logic [3:0]  ten;
  logic        conv_sel;   // 0: humidity, 1: temperature
  logic [7:0]  t_q;
  logic [11:0] rh_bcd, t_bcd;
  logic        conv_last;

  // Line output.
  logic [4:0]  idx, idx_nxt;
  logic        push, last_byte;
  logic [7:0]  next_byte, wdata;
  logic [4:0]  pos;
  logic        in_pfx;
`ifdef DHT_REPORT_SEQ_EN
  logic [7:0]  seq;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction
`endif

  function automatic logic [7:0] dig_char(input logic [3:0] d);
    return 8'h30 | {4'h0, d};
  endfunction

  assign period_wrap = (period_cnt == PER_W'(PERIOD_CYC - 1));
  assign tmo_hit     = (state == WAIT_DONE) && (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));
  assign conv_last   = conv_sel && (work < 8'd10);
  assign io.fifo_push  = push;
  assign io.fifo_wdata = wdata;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state and handshake outputs.
  always_comb begin
    // NOTE: every output gets a default first; a missed branch would otherwise infer a latch.
    next_state   = state;
    io.dht_start = 1'b0;
    push         = 1'b0;
    last_byte    = 1'b0;
    busy         = (state != IDLE);
    case (state)
      IDLE:      if (pending) next_state = TRIG;
      TRIG: begin
        io.dht_start = 1'b1;
        next_state   = WAIT_DONE;
      end
      WAIT_DONE: begin
        // A done pulse in the timeout cycle takes priority over the timeout.
        if (io.dht_done)  next_state = io.dht_valid ? CONV : ERR_SEND;
        else if (tmo_hit) next_state = ERR_SEND;
      end
      CONV:      if (conv_last) next_state = SEND;
      SEND: begin
        push      = !io.fifo_full;
        last_byte = (idx == 5'(GOOD_LEN - 1));
        if (push && last_byte) next_state = IDLE;
      end
      ERR_SEND: begin
        push      = !io.fifo_full;
        last_byte = (idx == 5'(ERR_LEN - 1));
        if (push && last_byte) next_state = IDLE;
      end
      default:   next_state = IDLE;
    endcase
  end

  // Periodic trigger timer and the single coalescing request bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period_cnt <= '0;
      pending    <= 1'b0;
    end else begin
      if (!auto_en || period_wrap) period_cnt <= '0;
      else                         period_cnt <= period_cnt + 1'b1;
      // A new request in the cycle IDLE consumes pending is kept, not lost.
      if (req || (auto_en && period_wrap)) pending <= 1'b1;
      else if (state == IDLE)              pending <= 1'b0;
    end
  end

  // Response timeout counter, restarted on every trigger.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     tmo_cnt <= '0;
    else if (state == TRIG)      tmo_cnt <= '0;
    else if (state == WAIT_DONE) tmo_cnt <= tmo_cnt + 1'b1;
  end

  // Capture on a good done, then binary-to-BCD by one subtraction per cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      work     <= '0;
      hun      <= '0;
      ten      <= '0;
      conv_sel <= 1'b0;
      t_q      <= '0;
      rh_bcd   <= '0;
      t_bcd    <= '0;
    end else if (state == WAIT_DONE && io.dht_done && io.dht_valid) begin
      work     <= io.rh_data;
      t_q      <= io.t_data;
      hun      <= '0;
      ten      <= '0;
      conv_sel <= 1'b0;
    end else if (state == CONV) begin
      if (work >= 8'd100) begin
        work <= work - 8'd100;
        hun  <= hun + 1'b1;
      end else if (work >= 8'd10) begin
        work <= work - 8'd10;
        ten  <= ten + 1'b1;
      end else if (!conv_sel) begin
        rh_bcd   <= {2'b00, hun, ten, work[3:0]};
        work     <= t_q;
        hun      <= '0;
        ten      <= '0;
        conv_sel <= 1'b1;
      end else begin
        t_bcd <= {2'b00, hun, ten, work[3:0]};
      end
    end
  end

  // Byte that will sit on fifo_wdata in the next cycle.
  always_comb begin
    if (state != SEND && state != ERR_SEND) idx_nxt = '0;
    else if (push)                          idx_nxt = idx + 1'b1;
    else                                    idx_nxt = idx;
`ifdef DHT_REPORT_SEQ_EN
    in_pfx = (idx_nxt < 5'd4);
    pos    = idx_nxt - 5'd4;
`else
    in_pfx = 1'b0;
    pos    = idx_nxt;
`endif
    next_byte = 8'h00;
    if (in_pfx) begin
`ifdef DHT_REPORT_SEQ_EN
      case (idx_nxt[1:0])
        2'd0:    next_byte = "#";
        2'd1:    next_byte = hex_char(seq[7:4]);
        2'd2:    next_byte = hex_char(seq[3:0]);
        default: next_byte = " ";
      endcase
`endif
    end else if (next_state == ERR_SEND) begin
      case (pos)
        5'd0:    next_byte = "E";
        5'd1:    next_byte = "R";
        5'd2:    next_byte = "R";
        5'd3:    next_byte = 8'h0D;
        default: next_byte = 8'h0A;
      endcase
    end else begin
      case (pos)
        5'd0:    next_byte = "H";
        5'd1:    next_byte = "=";
        5'd2:    next_byte = dig_char(rh_bcd[11:8]);
        5'd3:    next_byte = dig_char(rh_bcd[7:4]);
        5'd4:    next_byte = dig_char(rh_bcd[3:0]);
        5'd5:    next_byte = " ";
        5'd6:    next_byte = "T";
        5'd7:    next_byte = "=";
        5'd8:    next_byte = dig_char(t_bcd[11:8]);
        5'd9:    next_byte = dig_char(t_bcd[7:4]);
        5'd10:   next_byte = dig_char(t_bcd[3:0]);
        5'd11:   next_byte = 8'h0D;
        default: next_byte = 8'h0A;
      endcase
    end
  end

  // Byte index and registered write data; index moves only on an accepted push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx   <= '0;
      wdata <= '0;
    end else begin
      idx <= idx_nxt;
      if (next_state == SEND || next_state == ERR_SEND) wdata <= next_byte;
      else                                              wdata <= 8'h00;
    end
  end

`ifdef DHT_REPORT_SEQ_EN
  // Line sequence number, advanced once the final byte of any line is pushed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    seq <= '0;
    else if (push && last_byte) seq <= seq + 1'b1;
  end
`endif

  // Saturating error-line counter, bumped on entry to ERR_SEND.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_cnt <= '0;
    else if (state != ERR_SEND && next_state == ERR_SEND && err_cnt != 8'hFF)
      err_cnt <= err_cnt + 1'b1;
  end

endmodule

// File: tb/tb_dht11_uart_reporter.sv
// Self-checking bench for dht11_uart_reporter: a DHT11 controller model answers
// dht_start, pushes the expected text line into a scoreboard queue, and a
// monitor pops and compares each FIFO byte. Table-driven reads plus hand-written
// sequences for late done, auto trigger with coalesced requests, and reset mid-line.
module tb_dht11_uart_reporter;
  localparam int CLK_HZ     = 1000;
  localparam int PERIOD_MS  = 200;
  localparam int TIMEOUT_MS = 5;
`ifdef DHT_REPORT_SEQ_EN
  localparam int PFX = 4;
`else
  localparam int PFX = 0;
`endif

  logic       clk = 1'b0;
  logic       rst, auto_en, req;
  logic       busy;
  logic [7:0] err_cnt;

  dht11_uart_reporter_if bus ();

  dht11_uart_reporter #(
    .CLK_HZ(CLK_HZ), .PERIOD_MS(PERIOD_MS), .TIMEOUT_MS(TIMEOUT_MS)
  ) dut (
    .clk(clk), .rst(rst), .auto_en(auto_en), .req(req),
    .io(bus), .busy(busy), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  int         exp_err = 0;
  int         seq_no  = 0;

  function automatic logic [7:0] hex_digit(input int n);
    return (n < 10) ? 8'(48 + n) : 8'(55 + n);
  endfunction

  task automatic push_line(input bit good, input int rh, input int t);
`ifdef DHT_REPORT_SEQ_EN
    exp_q.push_back("#");
    exp_q.push_back(hex_digit(seq_no / 16));
    exp_q.push_back(hex_digit(seq_no % 16));
    exp_q.push_back(" ");
`endif
    if (good) begin
      exp_q.push_back("H"); exp_q.push_back("=");
      exp_q.push_back(8'(48 + rh / 100));
      exp_q.push_back(8'(48 + (rh / 10) % 10));
      exp_q.push_back(8'(48 + rh % 10));
      exp_q.push_back(" ");
      exp_q.push_back("T"); exp_q.push_back("=");
      exp_q.push_back(8'(48 + t / 100));
      exp_q.push_back(8'(48 + (t / 10) % 10));
      exp_q.push_back(8'(48 + t % 10));
    end else begin
      exp_q.push_back("E"); exp_q.push_back("R"); exp_q.push_back("R");
      if (exp_err < 255) exp_err++;
    end
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
    seq_no = (seq_no + 1) % 256;
  endtask

  // ---------------- DHT11 controller model ----------------
  bit   m_respond = 1'b1;
  bit   m_valid   = 1'b1;
  int   m_rh = 0, m_t = 0;
  int   m_delay   = 2;
  int   countdown = 0;
  bit   late_pulse = 1'b0;
  int   done_cyc = 0;

  always @(posedge clk) begin
    #1;
    bus.dht_done = 1'b0;
    if (rst) begin
      countdown = 0;
    end else begin
      if (late_pulse) begin
        bus.dht_done  = 1'b1;
        bus.dht_valid = 1'b1;
        late_pulse    = 1'b0;
      end
      if (countdown > 0) begin
        countdown--;
        if (countdown == 0) begin
          bus.dht_done  = 1'b1;
          bus.dht_valid = m_valid;
          bus.rh_data   = 8'(m_rh);
          bus.t_data    = 8'(m_t);
          done_cyc      = cyc;
        end
      end
      if (bus.dht_start) begin
        if (m_respond) countdown = m_delay;
        push_line(m_respond && m_valid, m_rh, m_t);
      end
    end
  end

  // FIFO full generator.
  bit full_rand = 1'b0;
  always @(posedge clk) begin
    #1;
    bus.fifo_full = full_rand ? 1'($urandom_range(0, 1)) : 1'b0;
  end

  // ---------------- monitor ----------------
  int start_cnt = 0, start_cyc = 0;
  bit prev_start = 1'b0;
  int line_pushes = 0, first_push_cyc = 0, last_push_cyc = 0;

  always @(negedge clk) begin
    if (rst) begin
      prev_start = 1'b0;
    end else begin
      if (bus.dht_start) begin
        start_cnt++;
        start_cyc = cyc;
        check("start_single_cycle", 32'(prev_start), 0);
      end
      prev_start = bus.dht_start;
      if (bus.fifo_push) begin
        logic [7:0] b;
        check("push_while_full", 32'(bus.fifo_full), 0);
        check("push_expected", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          b = exp_q.pop_front();
          check("fifo_byte", 32'(bus.fifo_wdata), 32'(b));
        end
        if (line_pushes == 0) first_push_cyc = cyc;
        last_push_cyc = cyc;
        line_pushes++;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic pulse_req();
    @(posedge clk); #1 req = 1'b1;
    @(posedge clk); #1 req = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    int n = 0;
    while (!busy && n < budget) begin @(negedge clk); n++; end
    while (busy && n < budget)  begin @(negedge clk); n++; end
    ok = !busy && (n < budget);
  endtask

  typedef struct {
    int rh;
    int t;
    bit valid;
    bit respond;
    bit rand_full;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int base, e0, s1, s2, len;

    vecs[0] = '{45, 23, 1'b1, 1'b1, 1'b0};
    vecs[1] = '{10, 20, 1'b0, 1'b1, 1'b0};   // checksum failure
    vecs[2] = '{0,  0,  1'b1, 1'b0, 1'b0};   // controller silent -> timeout
    vecs[3] = '{255, 0, 1'b1, 1'b1, 1'b1};   // extremes, FIFO back-pressure
    vecs[4] = '{199, 99, 1'b1, 1'b1, 1'b0};  // longest conversion
    vecs[5] = '{100, 10, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{7, 250, 1'b1, 1'b1, 1'b1};

    rst = 1'b1; auto_en = 1'b0; req = 1'b0;
    bus.fifo_full = 1'b0; bus.dht_done = 1'b0; bus.dht_valid = 1'b0;
    bus.rh_data = '0; bus.t_data = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", 32'(busy), 0);
    check("reset_err_cnt", 32'(err_cnt), 0);
    check("reset_fifo_push", 32'(bus.fifo_push), 0);
    check("reset_fifo_wdata", 32'(bus.fifo_wdata), 0);
    check("reset_dht_start", 32'(bus.dht_start), 0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (20) @(negedge clk);
    check("idle_no_start", 32'(start_cnt), 0);

    // Table-driven single reads.
    foreach (vecs[i]) begin
      m_rh = vecs[i].rh; m_t = vecs[i].t;
      m_valid = vecs[i].valid; m_respond = vecs[i].respond;
      full_rand = vecs[i].rand_full;
      line_pushes = 0;
      base = start_cnt;
      len = ((vecs[i].valid && vecs[i].respond) ? 13 : 5) + PFX;
      pulse_req();
      wait_idle(2000, ok);
      full_rand = 1'b0;
      check("line_done_in_time", 32'(ok), 1);
      check("one_start", 32'(start_cnt - base), 1);
      check("queue_drained", 32'(exp_q.size()), 0);
      check("line_len", 32'(line_pushes), 32'(len));
      check("err_cnt", 32'(err_cnt), 32'(exp_err));
      if (!vecs[i].rand_full)
        check("back_to_back", 32'(last_push_cyc - first_push_cyc), 32'(len - 1));
      if (!vecs[i].respond)
        check("timeout_latency", 32'(first_push_cyc - start_cyc), 6);
      else if (vecs[i].valid && !vecs[i].rand_full)
        check("conv_bound", 32'((first_push_cyc - done_cyc) <= 27), 1);
      repeat (3) @(negedge clk);
    end

    // Timeout, then a late dht_done while idle must be ignored.
    m_respond = 1'b0; line_pushes = 0; base = start_cnt;
    pulse_req();
    wait_idle(500, ok);
    check("timeout_line_done", 32'(ok), 1);
    @(posedge clk); #1 late_pulse = 1'b1;
    repeat (40) @(negedge clk);
    check("late_done_no_start", 32'(start_cnt - base), 1);
    check("late_done_idle", 32'(busy), 0);
    check("late_done_no_bytes", 32'(exp_q.size()), 0);
    check("late_done_err_cnt", 32'(err_cnt), 32'(exp_err));

    // Periodic trigger, then three requests while busy coalesce into one read.
    m_respond = 1'b1; m_valid = 1'b1; m_rh = 12; m_t = 34;
    base = start_cnt;
    @(posedge clk); #1 auto_en = 1'b1; e0 = cyc;
    for (int n = 0; n < 260 && start_cnt == base; n++) @(negedge clk);
    check("auto_first_start", 32'(start_cnt - base), 1);
    check("auto_period", 32'(start_cyc - e0), 201);
    s1 = start_cyc;
    @(posedge clk); #1 auto_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      pulse_req();
      @(negedge clk);
      check("busy_during_req", 32'(busy), 1);
    end
    for (int n = 0; n < 300 && start_cnt < base + 2; n++) @(negedge clk);
    s2 = start_cyc;
    check("coalesced_start", 32'(start_cnt - base), 2);
    check("start_spacing", 32'((s2 - s1) >= 13 + PFX + 2), 1);
    wait_idle(500, ok);
    repeat (300) @(negedge clk);
    check("no_extra_reads", 32'(start_cnt - base), 2);
    check("auto_queue_drained", 32'(exp_q.size()), 0);

    // Asynchronous reset in the middle of a line.
    m_rh = 88; m_t = 66; line_pushes = 0;
    pulse_req();
    for (int n = 0; n < 200 && line_pushes < 3; n++) @(negedge clk);
    check("midline_reached", 32'(line_pushes >= 3), 1);
    @(posedge clk); #1 rst = 1'b1;
    exp_q.delete(); exp_err = 0; seq_no = 0;
    @(negedge clk);
    check("midreset_busy", 32'(busy), 0);
    check("midreset_push", 32'(bus.fifo_push), 0);
    check("midreset_err_cnt", 32'(err_cnt), 0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (30) @(negedge clk);
    check("after_reset_idle", 32'(busy), 0);

    // Recovery read after reset.
    m_rh = 45; m_t = 23; line_pushes = 0;
    pulse_req();
    wait_idle(500, ok);
    check("recovery_done", 32'(ok), 1);
    check("recovery_len", 32'(line_pushes), 32'(13 + PFX));
    check("recovery_drained", 32'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
